// File: rtl/lbp_histogram_if.sv
// Bundle of the LBP sample stream and the histogram readout handshake.
// The histogram block is the slave; whoever feeds samples and drains bins is the master.
interface lbp_histogram_if #(
  parameter int CNT_W = 15
) ();
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             lbp_finish;
  logic             hist_clear;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             hist_done;
  logic             busy;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_clear, hist_ready,
    input  hist_valid, hist_bin, hist_count, hist_done, busy
  );

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_clear, hist_ready,
    output hist_valid, hist_bin, hist_count, hist_done, busy
  );
endinterface

// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes over one frame, then an in-order bin readout.
// Bins live in a register array updated in the same cycle as the sample, so
// back-to-back samples with the same code never lose an increment.
module lbp_histogram #(
  parameter int CNT_W       = 15,
  parameter int COL_W       = 7,
  parameter int SKIP_BORDER = 1
) (
  input logic            clk,
  input logic            reset,
  lbp_histogram_if.slave bus
);
  localparam int ROW_W = 14 - COL_W;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] bin_q [256];

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             on_border;
  logic             bin_we_d;
  logic [CNT_W-1:0] bin_d;
  logic             clear_en;

  assign row = bus.lbp_addr[13:COL_W];
  assign col = bus.lbp_addr[COL_W-1:0];

  // Decide whether this cycle's sample is counted and what the bin becomes
  always_comb begin
    on_border = (row == '0) || (row == '1) || (col == '0) || (col == '1);
    bin_we_d  = (state_q == ST_ACCUM) && bus.lbp_valid &&
                !((SKIP_BORDER != 0) && on_border);
    // Saturate instead of wrapping so a full bin stays at its maximum
    if (bin_q[bus.lbp_data] == '1) begin
      bin_d = bin_q[bus.lbp_data];
    end else begin
      bin_d = bin_q[bus.lbp_data] + 1'b1;
    end
    clear_en = (state_q == ST_DONE) && bus.hist_clear;
  end

  // Bin array: zeroed by reset or by a clear in DONE, otherwise one increment per sample
  always_ff @(posedge clk) begin
    if (reset || clear_en) begin
      for (int i = 0; i < 256; i++) begin
        bin_q[i] <= '0;
      end
    end else if (bin_we_d) begin
      bin_q[bus.lbp_data] <= bin_d;
    end
  end

  // State and drain index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and drain index; the 8-bit index wraps to 0 after bin 255
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_ACCUM: begin
        if (bus.lbp_finish) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.hist_ready) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'd255) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.hist_clear) begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs come only from registered state, index and bins
  always_comb begin
    bus.hist_valid = 1'b0;
    bus.hist_bin   = '0;
    bus.hist_count = '0;
    bus.hist_done  = 1'b0;
    bus.busy       = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        bus.busy = 1'b1;
      end
      ST_DRAIN: begin
        bus.busy       = 1'b1;
        bus.hist_valid = 1'b1;
        bus.hist_bin   = idx_q;
        bus.hist_count = bin_q[idx_q];
      end
      ST_DONE: begin
        bus.hist_done = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_lbp_histogram.sv
// Bench for lbp_histogram: two instances (border skipping on and off) fed the
// same sample stream; expected bins are queued at frame end and popped per accepted bin.
module tb_lbp_histogram;
  localparam int CNT_W = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_histogram_if #(.CNT_W(CNT_W)) if_a ();
  lbp_histogram_if #(.CNT_W(CNT_W)) if_b ();

  lbp_histogram #(.CNT_W(CNT_W), .COL_W(7), .SKIP_BORDER(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  lbp_histogram #(.CNT_W(CNT_W), .COL_W(7), .SKIP_BORDER(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  typedef struct {
    int bin;
    int count;
  } exp_t;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  code;
    int          reps;
    bit          on_finish;
    bit          toggle;
    int          exp_a;
    int          exp_b;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   exp_a[256];
  int   exp_b[256];
  vec_t vecs[9];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [13:0] addr, input logic [7:0] data,
                       input logic fin, input logic clr, input logic rdy);
    if_a.lbp_valid = v;   if_b.lbp_valid = v;
    if_a.lbp_addr = addr; if_b.lbp_addr = addr;
    if_a.lbp_data = data; if_b.lbp_data = data;
    if_a.lbp_finish = fin; if_b.lbp_finish = fin;
    if_a.hist_clear = clr; if_b.hist_clear = clr;
    if_a.hist_ready = rdy; if_b.hist_ready = rdy;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) begin
      exp_a[i] = 0;
      exp_b[i] = 0;
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < 256; i++) begin
      q_a.push_back('{bin: i, count: exp_a[i]});
      q_b.push_back('{bin: i, count: exp_b[i]});
    end
  endtask

  task automatic finish_frame();
    push_expected();
    drive(1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid_a"}, if_a.hist_valid, 0);
    check({tag, "_bin_a"}, if_a.hist_bin, 0);
    check({tag, "_count_a"}, if_a.hist_count, 0);
    check({tag, "_done_a"}, if_a.hist_done, 0);
    check({tag, "_busy_a"}, if_a.busy, 1);
    check({tag, "_valid_b"}, if_b.hist_valid, 0);
    check({tag, "_busy_b"}, if_b.busy, 1);
  endtask

  // Drain from the first DRAIN cycle; a stray sample in that cycle must be ignored.
  task automatic drain(input bit toggle, input int abort_at);
    int   cyc = 0;
    int   accepted = 0;
    bit   holding = 0;
    int   held_bin = 0;
    int   held_cnt = 0;
    logic rdy;
    exp_t ea, eb;
    while (cyc < 600 && !if_a.hist_done && !(abort_at >= 0 && accepted == abort_at)) begin
      rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      drive(cyc == 0, 14'd129, 8'h5A, 1'b0, 1'b0, rdy);
      check("drain_valid_a", if_a.hist_valid, 1);
      check("drain_valid_b", if_b.hist_valid, 1);
      if (holding) begin
        check("hold_bin", if_a.hist_bin, held_bin);
        check("hold_count", if_a.hist_count, held_cnt);
      end
      holding = 0;
      if (rdy) begin
        if (q_a.size() == 0 || q_b.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          ea = q_a.pop_front();
          eb = q_b.pop_front();
          check("bin_a", if_a.hist_bin, ea.bin);
          check("count_a", if_a.hist_count, ea.count);
          check("bin_b", if_b.hist_bin, eb.bin);
          check("count_b", if_b.hist_count, eb.count);
        end
        accepted++;
      end else begin
        holding  = 1;
        held_bin = if_a.hist_bin;
        held_cnt = if_a.hist_count;
      end
      step();
      cyc++;
    end
    drive(1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    if (abort_at < 0) begin
      check("drain_cycles", cyc, toggle ? 511 : 256);
      check("done_a", if_a.hist_done, 1);
      check("done_b", if_b.hist_done, 1);
      check("done_busy_a", if_a.busy, 0);
      check("done_valid_a", if_a.hist_valid, 0);
      check("scoreboard_left", q_a.size() + q_b.size(), 0);
    end
  endtask

  // In DONE: finish and samples have no effect, then clear re-arms
  task automatic done_and_clear();
    drive(1'b1, 14'd129, 8'd3, 1'b1, 1'b0, 1'b0);
    step();
    check("done_hold_a", if_a.hist_done, 1);
    check("done_hold_valid_a", if_a.hist_valid, 0);
    drive(1'b0, 14'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("clear");
  endtask

  task automatic sample(input logic [13:0] addr, input logic [7:0] data, input logic fin);
    drive(1'b1, addr, data, fin, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    vecs[0] = '{14'd129,   8'h5A, 5, 1'b0, 1'b0, 5, 5};
    vecs[1] = '{14'd129,   8'h07, 1, 1'b1, 1'b0, 1, 1};
    vecs[2] = '{14'd0,     8'h11, 1, 1'b0, 1'b1, 0, 1};
    vecs[3] = '{14'd127,   8'h22, 2, 1'b0, 1'b0, 0, 2};
    vecs[4] = '{14'd16383, 8'h33, 3, 1'b0, 1'b0, 0, 3};
    vecs[5] = '{14'd16261, 8'h44, 1, 1'b0, 1'b0, 0, 1};
    vecs[6] = '{14'd640,   8'h55, 2, 1'b0, 1'b0, 0, 2};
    vecs[7] = '{14'd767,   8'h66, 1, 1'b0, 1'b0, 0, 1};
    vecs[8] = '{14'd16254, 8'hFF, 4, 1'b0, 1'b1, 4, 4};

    reset = 1'b1;
    drive(1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Sweep 1: every pixel code 0; only the 126x126 interior counts with border skipping
    clear_exp();
    exp_a[0] = 15876;
    exp_b[0] = 16384;
    for (int a = 0; a < 16384; a++) sample(14'(a), 8'd0, 1'b0);
    finish_frame();
    $display("frame sweep_zero: drain start");
    drain(1'b0, -1);
    done_and_clear();

    // Sweep 2: code = addr[7:0]; each code covers 64 pixels of one column parity pair
    clear_exp();
    for (int b = 0; b < 256; b++) begin
      exp_b[b] = 64;
      exp_a[b] = ((b % 128) == 0 || (b % 128) == 127) ? 0 : 63;
    end
    for (int a = 0; a < 16384; a++) sample(14'(a), 8'(a % 256), 1'b0);
    finish_frame();
    $display("frame sweep_addr: drain start");
    drain(1'b0, -1);
    done_and_clear();

    // Table-driven single-code frames
    for (int v = 0; v < 9; v++) begin
      clear_exp();
      exp_a[vecs[v].code] = vecs[v].exp_a;
      exp_b[vecs[v].code] = vecs[v].exp_b;
      for (int r = 0; r < vecs[v].reps; r++) begin
        if (vecs[v].on_finish && r == vecs[v].reps - 1) begin
          push_expected();
          sample(vecs[v].addr, vecs[v].code, 1'b1);
        end else begin
          sample(vecs[v].addr, vecs[v].code, 1'b0);
        end
      end
      if (!vecs[v].on_finish) finish_frame();
      $display("vector %0d: addr=%0d code=%0d reps=%0d", v, vecs[v].addr, vecs[v].code, vecs[v].reps);
      drain(vecs[v].toggle, -1);
      done_and_clear();
    end

    // Reset in the middle of a drain at index 100
    clear_exp();
    exp_a[9] = 3;
    exp_b[9] = 3;
    for (int r = 0; r < 3; r++) sample(14'd300, 8'd9, 1'b0);
    finish_frame();
    drain(1'b0, 100);
    check("abort_idx", if_a.hist_bin, 100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("midreset");
    q_a.delete();
    q_b.delete();
    clear_exp();
    finish_frame();
    $display("frame after mid-drain reset: drain start");
    drain(1'b0, -1);
    done_and_clear();

    // After a clear in DONE, one sample of code 7
    clear_exp();
    exp_a[7] = 1;
    exp_b[7] = 1;
    sample(14'd1000, 8'd7, 1'b0);
    finish_frame();
    $display("frame single code 7: drain start");
    drain(1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
